// File: rtl/alu_cmd_issuer.sv
// Purpose: buffers ALU commands in a small FIFO and issues them one at a time to alu_top, returning tagged results.
// Latency: a pop in cycle t gives rsp_valid in cycle t+ALU_LAT+2, and a push into an empty idle block responds after ALU_LAT+3 cycles.
// Backpressure: cmd_ready falls only when the FIFO is full; a response is held on rsp_* until rsp_ready, and nothing new issues meanwhile.
module alu_cmd_issuer #(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // command port
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [N-1:0]             cmd_operand1,
  input  logic [N-1:0]             cmd_operand2,
  input  logic [1:0]               cmd_operation,
  // alu_top drive and return
  output logic [N-1:0]             alu_operand1,
  output logic [N-1:0]             alu_operand2,
  output logic [1:0]               alu_operation,
  input  logic [N:0]               alu_result,
  // response port
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N:0]               rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  // status
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(ALU_LAT + 1);

  // One queued command; opcode and operands travel together untouched.
  typedef struct packed {
    logic [1:0]   operation;
    logic [N-1:0] operand2;
    logic [N-1:0] operand1;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  cmd_t   cmd_in;
  cmd_t   head;

  state_t           state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [TAG_W-1:0] seq_q;
  logic [N-1:0]     alu_operand1_q;
  logic [N-1:0]     alu_operand2_q;
  logic [1:0]       alu_operation_q;
  logic             rsp_valid_q;
  logic [N:0]       rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // Ready depends on fullness only; a same-cycle pop does not open a slot.
  assign cmd_ready  = !reset && !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  // Only the FSM pops, and only from IDLE with something queued.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  assign cmd_in.operand1  = cmd_operand1;
  assign cmd_in.operand2  = cmd_operand2;
  assign cmd_in.operation = cmd_operation;
  assign head             = mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------

  // Issue / wait / respond sequencer with all its outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wcnt_q          <= '0;
      seq_q           <= '0;
      alu_operand1_q  <= '0;
      alu_operand2_q  <= '0;
      alu_operation_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_tag_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ALU ports keep their last values until something is popped.
          if (pop) begin
            alu_operand1_q  <= head.operand1;
            alu_operand2_q  <= head.operand2;
            alu_operation_q <= head.operation;
            rsp_tag_q       <= seq_q;
            seq_q           <= seq_q + 1'b1;
            wcnt_q          <= WCNT_W'(ALU_LAT);
            state_q         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The extra zero-count cycle lets a registered ALU settle before capture.
          if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Response held stable until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_operand1  = alu_operand1_q;
  assign alu_operand2  = alu_operand2_q;
  assign alu_operation = alu_operation_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = rsp_tag_q;
  assign fifo_count    = count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a registered ALU model
// (op0 add, op1 subtract, op2 and, op3 or), all checks through chk().
module tb_alu_cmd_issuer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_operand1;
  logic [3:0] cmd_operand2;
  logic [1:0] cmd_operation;
  logic [3:0] alu_operand1;
  logic [3:0] alu_operand2;
  logic [1:0] alu_operation;
  logic [4:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_result;
  logic [3:0] rsp_tag;
  logic [2:0] fifo_count;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  alu_cmd_issuer #(.N(4), .DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_operand1  (cmd_operand1),
    .cmd_operand2  (cmd_operand2),
    .cmd_operation (cmd_operation),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_tag       (rsp_tag),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU stand-in for alu_top.
  always @(posedge clk) begin
    case (alu_operation)
      2'd0:    alu_result <= {1'b0, alu_operand1} + {1'b0, alu_operand2};
      2'd1:    alu_result <= {1'b0, alu_operand1} - {1'b0, alu_operand2};
      2'd2:    alu_result <= {1'b0, alu_operand1 & alu_operand2};
      default: alu_result <= {1'b0, alu_operand1 | alu_operand2};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    cmd_valid     = 1'b1;
    cmd_operand1  = a;
    cmd_operand2  = b;
    cmd_operation = op;
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until rsp_valid is seen at a falling edge.
  task automatic wait_rsp();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Directed command table for the fill/drain test, results hand-computed.
  logic [3:0] t_a   [6] = '{4'd3, 4'd15, 4'd9, 4'd12, 4'd5,  4'd0};
  logic [3:0] t_b   [6] = '{4'd4, 4'd15, 4'd2, 4'd10, 4'd10, 4'd1};
  logic [1:0] t_op  [6] = '{2'd0, 2'd0,  2'd1, 2'd2,  2'd3,  2'd0};
  logic [4:0] t_res [6] = '{5'd7, 5'd30, 5'd7, 5'd8,  5'd15, 5'd1};

  initial begin
    bit         seen_rsp;
    logic [3:0] a;

    // ---- 1: reset with cmd_valid high ----
    reset         = 1'b1;
    rsp_ready     = 1'b0;
    cmd_valid     = 1'b1;
    cmd_operand1  = 4'd1;
    cmd_operand2  = 4'd1;
    cmd_operation = 2'd0;
    step();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op1", alu_operand1, 0);
    chk("rst_alu_op2", alu_operand2, 0);
    chk("rst_alu_opn", alu_operation, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    step();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_count", fifo_count, 0);

    // ---- 2: single command latency ----
    rsp_ready = 1'b1;
    step();
    push_cmd(4'd7, 4'd10, 2'd0);
    @(negedge clk);
    chk("t2_count_after_push", fifo_count, 1);
    step();
    @(negedge clk);
    chk("t2_alu_op1", alu_operand1, 7);
    chk("t2_alu_op2", alu_operand2, 10);
    chk("t2_busy", busy, 1);
    chk("t2_count_after_pop", fifo_count, 0);
    step();
    @(negedge clk);
    chk("t2_rsp_early", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_result", rsp_result, 17);
    chk("t2_rsp_tag", rsp_tag, 0);
    step();
    @(negedge clk);
    chk("t2_rsp_dropped", rsp_valid, 0);
    chk("t2_idle", busy, 0);

    // ---- 3/4: fill FIFO under backpressure, pop while full, drain ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_valid     = 1'b1;
      cmd_operand1  = t_a[i];
      cmd_operand2  = t_b[i];
      cmd_operation = t_op[i];
      step();
    end
    cmd_operand1  = t_a[5];
    cmd_operand2  = t_b[5];
    cmd_operation = t_op[5];
    wait_rsp();
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", cmd_ready, 0);
    chk("t3_rsp0_result", rsp_result, t_res[0]);
    chk("t3_rsp0_tag", rsp_tag, 0);
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t4_idle_full_count", fifo_count, 4);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready", cmd_ready, 0);
    step();
    @(negedge clk);
    chk("t4_pop_no_push_count", fifo_count, 3);
    chk("t4_pop_busy", busy, 1);
    step();
    cmd_valid = 1'b0;
    for (int j = 1; j < 6; j++) begin
      wait_rsp();
      chk($sformatf("t3_rsp%0d_result", j), rsp_result, t_res[j]);
      chk($sformatf("t3_rsp%0d_tag", j), rsp_tag, j);
      step();
    end
    @(negedge clk);
    chk("t3_drained_count", fifo_count, 0);

    // ---- 5: tag wrap over 17 commands ----
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a = 4'(i);
      push_cmd(a, 4'd3, 2'd0);
      wait_rsp();
      chk($sformatf("t5_result%0d", i), rsp_result, 32'(i % 16) + 32'd3);
      chk($sformatf("t5_tag%0d", i), rsp_tag, 32'(i % 16));
      step();
    end

    // ---- 6: reset while in WAIT with two queued ----
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid     = 1'b1;
      cmd_operand1  = 4'(i + 1);
      cmd_operand2  = 4'd1;
      cmd_operation = 2'd0;
      step();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_count", fifo_count, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    seen_rsp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
      step();
    end
    chk("t6_no_rsp", seen_rsp, 0);
    chk("t6_count", fifo_count, 0);
    push_cmd(4'd2, 4'd2, 2'd0);
    wait_rsp();
    chk("t6_tag", rsp_tag, 0);
    chk("t6_result", rsp_result, 4);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
